// File: rtl/l2_fwd_engine.sv
// Learning L2 forwarding core: one frame per handshake, MAC table lookup/learn,
// flood on miss/broadcast, hairpin drop, periodic aging sweep.
module l2_fwd_engine #(
  parameter int ADDR_W     = 4,
  parameter int PAYLOAD_W  = 4,
  parameter int NPORTS     = 4,
  parameter int DEPTH      = 4,
  parameter int AGE_CYCLES = 1024
) (
  input  logic                 FPGA_CLK,
  input  logic                 FPGA_RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_port,
  input  logic [ADDR_W-1:0]    in_dst,
  input  logic [ADDR_W-1:0]    in_src,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NPORTS-1:0]    out_mask,
  output logic [ADDR_W-1:0]    out_dst,
  output logic [ADDR_W-1:0]    out_src,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_flood,
  output logic [7:0]           cnt_fwd,
  output logic [7:0]           cnt_flood,
  output logic [7:0]           cnt_drop
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = (AGE_CYCLES > 1) ? $clog2(AGE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] BCAST = '1;
  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  state_t state;

  logic [1:0]           l_port;
  logic [ADDR_W-1:0]    l_dst;
  logic [ADDR_W-1:0]    l_src;
  logic [PAYLOAD_W-1:0] l_payload;

  logic [DEPTH-1:0]  tbl_valid;
  logic [DEPTH-1:0]  tbl_hit;
  logic [ADDR_W-1:0] tbl_mac  [DEPTH];
  logic [1:0]        tbl_port [DEPTH];
  logic [IDX_W-1:0]  repl_ptr;
  logic [AGE_W-1:0]  age_timer;

  logic              dst_hit, src_hit, free_any;
  logic [IDX_W-1:0]  dst_idx, src_idx, free_idx, learn_idx;
  logic [1:0]        hit_port;
  logic              flood, drop, learn_en, age_wrap;
  logic [NPORTS-1:0] all_ports, ingress_bit, hit_bit;

  assign in_ready = (state == S_IDLE) && !FPGA_RST;

  // Lookup and learn both see the table as it stood before this frame.
  always_comb begin
    dst_hit  = 1'b0;
    src_hit  = 1'b0;
    free_any = 1'b0;
    dst_idx  = '0;
    src_idx  = '0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tbl_valid[i] && tbl_mac[i] == l_dst && !dst_hit) begin
        dst_hit = 1'b1;
        dst_idx = IDX_W'(i);
      end
      if (tbl_valid[i] && tbl_mac[i] == l_src && !src_hit) begin
        src_hit = 1'b1;
        src_idx = IDX_W'(i);
      end
      if (!tbl_valid[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    hit_port    = tbl_port[dst_idx];
    flood       = (l_dst == BCAST) || !dst_hit;
    drop        = (l_dst == l_src) || (dst_hit && hit_port == l_port);
    learn_en    = (l_src != NULL_ADDR) && (l_src != BCAST);
    learn_idx   = src_hit ? src_idx : (free_any ? free_idx : repl_ptr);
    age_wrap    = (age_timer == AGE_W'(AGE_CYCLES - 1));
    all_ports   = '1;
    ingress_bit = NPORTS'(1) << l_port;
    hit_bit     = NPORTS'(1) << hit_port;
  end

  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state       <= S_IDLE;
      l_port      <= '0;
      l_dst       <= '0;
      l_src       <= '0;
      l_payload   <= '0;
      tbl_valid   <= '0;
      tbl_hit     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_mac[i]  <= '0;
        tbl_port[i] <= '0;
      end
      repl_ptr    <= '0;
      age_timer   <= '0;
      out_valid   <= 1'b0;
      out_mask    <= '0;
      out_dst     <= '0;
      out_src     <= '0;
      out_payload <= '0;
      out_flood   <= 1'b0;
      cnt_fwd     <= '0;
      cnt_flood   <= '0;
      cnt_drop    <= '0;
    end else begin
      age_timer <= age_wrap ? '0 : age_timer + 1'b1;
      // Sweep is written first so a same-cycle learn write overrides it.
      if (age_wrap) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (!tbl_hit[i]) tbl_valid[i] <= 1'b0;
        tbl_hit <= '0;
      end

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            l_port    <= in_port;
            l_dst     <= in_dst;
            l_src     <= in_src;
            l_payload <= in_payload;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (learn_en) begin
            tbl_valid[learn_idx] <= 1'b1;
            tbl_hit[learn_idx]   <= 1'b1;
            tbl_mac[learn_idx]   <= l_src;
            tbl_port[learn_idx]  <= l_port;
            if (!src_hit && !free_any)
              repl_ptr <= (repl_ptr == IDX_W'(DEPTH - 1)) ? '0 : repl_ptr + 1'b1;
          end
          if (drop) begin
            cnt_drop <= cnt_drop + 8'd1;
            state    <= S_IDLE;
          end else begin
            out_valid   <= 1'b1;
            out_dst     <= l_dst;
            out_src     <= l_src;
            out_payload <= l_payload;
            out_flood   <= flood;
            out_mask    <= flood ? (all_ports & ~ingress_bit) : hit_bit;
            if (flood) cnt_flood <= cnt_flood + 8'd1;
            else       cnt_fwd   <= cnt_fwd + 8'd1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_fwd_engine.sv
// Directed bench for l2_fwd_engine: flood/learn, forward, hairpin drop,
// backpressure, table replacement, aging and mid-frame reset.
module tb_l2_fwd_engine;

  logic       FPGA_CLK = 1'b0;
  logic       FPGA_RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_port = '0;
  logic [3:0] in_dst = '0, in_src = '0, in_payload = '0;
  logic       out_valid, out_ready = 1'b1, out_flood;
  logic [3:0] out_mask, out_dst, out_src, out_payload;
  logic [7:0] cnt_fwd, cnt_flood, cnt_drop;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [3:0] A = 4'hA, B = 4'hB, C = 4'hC, D = 4'hD, E = 4'hE, F = 4'hF;

  l2_fwd_engine #(
    .ADDR_W(4), .PAYLOAD_W(4), .NPORTS(4), .DEPTH(4), .AGE_CYCLES(1024)
  ) dut (
    .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_port(in_port),
    .in_dst(in_dst), .in_src(in_src), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_dst(out_dst), .out_src(out_src), .out_payload(out_payload),
    .out_flood(out_flood), .cnt_fwd(cnt_fwd), .cnt_flood(cnt_flood),
    .cnt_drop(cnt_drop)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  // Presents one frame, returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] p, input logic [3:0] s, input logic [3:0] d,
                      input logic [3:0] pl);
    bit ok = 1'b0;
    @(negedge FPGA_CLK);
    in_valid = 1'b1; in_port = p; in_src = s; in_dst = d; in_payload = pl;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) begin
        @(posedge FPGA_CLK);
        ok = 1'b1;
      end else begin
        @(negedge FPGA_CLK);
      end
    end
    @(negedge FPGA_CLK);
    in_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL send_accept: got no accept, want accept within 50 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge FPGA_CLK);
    FPGA_RST = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    FPGA_RST = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [42:0] got;
    FPGA_RST = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    got = {in_ready, out_valid, out_flood, out_mask, out_dst, out_src, out_payload,
           cnt_fwd, cnt_flood, cnt_drop};
    tests_run++;
    if (got !== 43'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0", got);
    end
    FPGA_RST = 1'b0;
    @(negedge FPGA_CLK);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_flood_learn();
    send(2'd0, A, C, 4'h5);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL latency_lookup: out_valid got %b want 0", out_valid);
    end
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_payload, out_src, out_dst} !== {2'b11, 4'b1110, 4'h5, A, C}) begin
      tests_failed++;
      $display("FAIL flood_frame: got v%b f%b m%b p%h s%h d%h want v1 f1 m1110 p5 sa dc",
               out_valid, out_flood, out_mask, out_payload, out_src, out_dst);
    end
    tests_run++;
    if (cnt_flood !== 8'd1) begin
      tests_failed++;
      $display("FAIL flood_count: got %0d want 1", cnt_flood);
    end
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL flood_done: got v%b r%b want v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_forward();
    send(2'd2, C, A, 4'h3);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_payload, out_src, out_dst} !== {2'b10, 4'b0001, 4'h3, C, A}) begin
      tests_failed++;
      $display("FAIL fwd_to_a: got v%b f%b m%b p%h s%h d%h want v1 f0 m0001 p3 sc da",
               out_valid, out_flood, out_mask, out_payload, out_src, out_dst);
    end
    tests_run++;
    if (cnt_fwd !== 8'd1) begin
      tests_failed++;
      $display("FAIL fwd_count1: got %0d want 1", cnt_fwd);
    end
    @(negedge FPGA_CLK);
    send(2'd0, A, C, 4'h8);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_payload} !== {2'b10, 4'b0100, 4'h8}) begin
      tests_failed++;
      $display("FAIL fwd_to_c: got v%b f%b m%b p%h want v1 f0 m0100 p8",
               out_valid, out_flood, out_mask, out_payload);
    end
    @(negedge FPGA_CLK);
  endtask

  task automatic test_drop();
    send(2'd0, A, A, 4'h1);
    tests_run++;
    if ({out_valid, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL drop_self_lookup: got v%b r%b want v0 r0", out_valid, in_ready);
    end
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, in_ready, cnt_drop} !== {2'b01, 8'd1}) begin
      tests_failed++;
      $display("FAIL drop_self: got v%b r%b drop%0d want v0 r1 drop1", out_valid, in_ready, cnt_drop);
    end
    send(2'd0, B, C, 4'h2);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_src} !== {2'b10, 4'b0100, B}) begin
      tests_failed++;
      $display("FAIL learn_b: got v%b f%b m%b s%h want v1 f0 m0100 sb",
               out_valid, out_flood, out_mask, out_src);
    end
    @(negedge FPGA_CLK);
    send(2'd0, A, B, 4'h4);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, in_ready, cnt_drop, cnt_fwd} !== {2'b01, 8'd2, 8'd3}) begin
      tests_failed++;
      $display("FAIL drop_hairpin: got v%b r%b drop%0d fwd%0d want v0 r1 drop2 fwd3",
               out_valid, in_ready, cnt_drop, cnt_fwd);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'd1, D, A, 4'h9);
    @(negedge FPGA_CLK);
    in_valid = 1'b1; in_port = 2'd3; in_src = B; in_dst = C; in_payload = 4'h6;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({out_valid, out_flood, out_mask, out_payload, out_src, out_dst, in_ready} !==
          {2'b10, 4'b0001, 4'h9, D, A, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_%0d: got v%b f%b m%b p%h s%h d%h r%b want v1 f0 m0001 p9 sd da r0",
                 i, out_valid, out_flood, out_mask, out_payload, out_src, out_dst, in_ready);
      end
      @(negedge FPGA_CLK);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, in_ready, cnt_fwd, cnt_flood, cnt_drop} !== {2'b01, 8'd4, 8'd1, 8'd2}) begin
      tests_failed++;
      $display("FAIL bp_release: got v%b r%b fwd%0d flood%0d drop%0d want v0 r1 fwd4 flood1 drop2",
               out_valid, in_ready, cnt_fwd, cnt_flood, cnt_drop);
    end
  endtask

  task automatic test_replace();
    do_reset();
    send(2'd0, A, F, 4'h1);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_dst} !== {2'b11, 4'b1110, F}) begin
      tests_failed++;
      $display("FAIL bcast_p0: got v%b f%b m%b d%h want v1 f1 m1110 df",
               out_valid, out_flood, out_mask, out_dst);
    end
    @(negedge FPGA_CLK);
    send(2'd1, B, F, 4'h2); repeat (2) @(negedge FPGA_CLK);
    send(2'd2, C, F, 4'h3); repeat (2) @(negedge FPGA_CLK);
    send(2'd3, D, F, 4'h4); repeat (2) @(negedge FPGA_CLK);
    send(2'd1, E, F, 4'h5); repeat (2) @(negedge FPGA_CLK);
    send(2'd3, D, A, 4'h6);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_payload} !== {2'b11, 4'b0111, 4'h6}) begin
      tests_failed++;
      $display("FAIL replaced_a: got v%b f%b m%b p%h want v1 f1 m0111 p6",
               out_valid, out_flood, out_mask, out_payload);
    end
    @(negedge FPGA_CLK);
    send(2'd2, C, E, 4'h7);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, cnt_flood, cnt_fwd} !== {2'b10, 4'b0010, 8'd6, 8'd1}) begin
      tests_failed++;
      $display("FAIL learned_e: got v%b f%b m%b flood%0d fwd%0d want v1 f0 m0010 flood6 fwd1",
               out_valid, out_flood, out_mask, cnt_flood, cnt_fwd);
    end
    @(negedge FPGA_CLK);
  endtask

  task automatic test_aging();
    do_reset();
    send(2'd0, A, F, 4'h1); repeat (2) @(negedge FPGA_CLK);
    repeat (1100) @(negedge FPGA_CLK);
    send(2'd2, C, A, 4'h2);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask} !== {2'b10, 4'b0001}) begin
      tests_failed++;
      $display("FAIL age_survive: got v%b f%b m%b want v1 f0 m0001", out_valid, out_flood, out_mask);
    end
    @(negedge FPGA_CLK);
    repeat (1000) @(negedge FPGA_CLK);
    send(2'd2, C, A, 4'h3);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, out_payload} !== {2'b11, 4'b1011, 4'h3}) begin
      tests_failed++;
      $display("FAIL age_expired: got v%b f%b m%b p%h want v1 f1 m1011 p3",
               out_valid, out_flood, out_mask, out_payload);
    end
    @(negedge FPGA_CLK);
  endtask

  task automatic test_reset_midop();
    logic [42:0] got;
    send(2'd1, B, C, 4'h7);
    FPGA_RST = 1'b1;
    @(negedge FPGA_CLK);
    got = {in_ready, out_valid, out_flood, out_mask, out_dst, out_src, out_payload,
           cnt_fwd, cnt_flood, cnt_drop};
    tests_run++;
    if (got !== 43'd0) begin
      tests_failed++;
      $display("FAIL midop_reset: got %h want 0", got);
    end
    FPGA_RST = 1'b0;
    @(negedge FPGA_CLK);
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midop_ready: got r%b v%b want r1 v0", in_ready, out_valid);
    end
    send(2'd2, C, A, 4'h4);
    @(negedge FPGA_CLK);
    tests_run++;
    if ({out_valid, out_flood, out_mask, cnt_flood} !== {2'b11, 4'b1011, 8'd1}) begin
      tests_failed++;
      $display("FAIL midop_table_clear: got v%b f%b m%b flood%0d want v1 f1 m1011 flood1",
               out_valid, out_flood, out_mask, cnt_flood);
    end
    @(negedge FPGA_CLK);
  endtask

  initial begin
    test_reset();
    test_flood_learn();
    test_forward();
    test_drop();
    test_backpressure();
    test_replace();
    test_aging();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
